extmem_ctrl: RTL and testbench
==============================

Name: extmem_ctrl

Overview:
- Memory-side bus controller directly upstream of the external memory model; sole master of its adr/data/byteen/rwb/en/done bus.
- Arbitrates instruction-cache line refills against data-cache refills and single-word write-throughs.
- Sequences each transaction word by word, honouring memory done, and returns read words with per-word valid strobes.

Parameters:
- AW, 13, word-address width of memory bus.
- LINE_WORDS, 4, words per refill burst (power of 2, 2..16).
- TMO_CYC, 255, timeout limit in cycles (used only with optional feature).

Ports:
- ph1  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ireq  in  1  icache refill request; held until idone.
- iadr  in  AW  icache miss word address.
- irdata  out  32  returned refill word.
- ivalid  out  1  irdata valid this cycle.
- idone  out  1  one-cycle pulse after the last refill word.
- dreq  in  1  dcache request; held until ddone.
- drwb  in  1  1 = line refill, 0 = single-word write.
- dadr  in  AW  dcache word address.
- dwdata  in  32  write data.
- dbyteen  in  4  write byte enables; bit0 = data[7:0] (little endian).
- drdata  out  32  returned refill word.
- dvalid  out  1  drdata valid this cycle.
- ddone  out  1  one-cycle completion pulse.
- adr  out  AW  memory word address.
- data  inout  32  memory data; driven only during writes, else 'z.
- byteen  out  4  memory byte enables.
- rwb  out  1  1 = read, 0 = write.
- en  out  1  memory access enable.
- done  in  1  memory word complete.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (reset=0, async):
  - FSM=IDLE, word counter=0.
  - en=0, rwb=1, byteen=0, adr=0, data='z.
  - ivalid/dvalid/idone/ddone=0, busy=0; priority token = D.
- States: IDLE, IRD, DRD, DWR, FIN.
- IDLE arbitration:
  - Both requests pending: grant the side holding the token; token then flips to the other side.
  - Only one pending: grant it; token unchanged.
  - Grant registers base address. Refills align it to line: low log2(LINE_WORDS) bits cleared, counter=0.
- IRD / DRD:
  - en=1, rwb=1, adr=base+counter.
  - Cycle with done=1: capture data into irdata/drdata; assert ivalid/dvalid next cycle for one cycle; counter increments.
  - After word LINE_WORDS-1: go to FIN.
  - done=0: hold all outputs (wait states unbounded unless timeout feature).
- DWR:
  - en=1, rwb=0, adr=dadr, byteen=dbyteen, data driven with dwdata.
  - On done=1: go to FIN.
- FIN:
  - en=0, rwb=1, data='z.
  - Pulse idone or ddone for the granted side; return to IDLE.
  - Minimum one idle-bus cycle between transactions.
- Latency: done tied high, refill of N words = N+2 cycles from grant to done pulse; write = 3 cycles.
- Address arithmetic: counter is log2(LINE_WORDS) bits and is OR'd into aligned base; wraps within the line, never carries into upper bits. Base at top of memory stays in range.
- Request dropped mid-transaction: ignored; transaction completes, done pulse still issued.
- Request input changes mid-burst: ignored; all fields latched at grant.
- Reset mid-transaction: immediate abort, bus released to 'z, no done pulse.
- rwb never changes while en=1 within a word.

Optional Feature:
- Macro: EXTMEM_CTRL_TIMEOUT_EN.
- Defined: an 8-bit+ counter tracks cycles en=1 without done.
  - Reaching TMO_CYC aborts the transaction to FIN.
  - Requester still gets its done pulse; sticky output port tmo_err (1 bit) set.
  - tmo_err cleared only by reset.
- Undefined: no counter; port tmo_err absent; wait is unbounded.

Decomposition:
- Shared package extmem_pkg:
  - FSM state encoding constants.
  - Byte-enable width (4) and data width (32).
  - LINE_WORDS default.
- One natural sub-module: extmem_arb (2-way round-robin arbiter with token flop, grant outputs).
- FSM, counter and bus drivers stay in the top.

Test Plan:
- ireq alone, iadr=0x013, memory words 0x10..0x13 = A0..A3, done=1:
  - adr sequence 0x010..0x013.
  - ivalid on 4 consecutive cycles with A0..A3.
  - idone 6 cycles after grant.
- dreq write, dadr=0x100, dwdata=0xDEADBEEF, dbyteen=4'b0101:
  - rwb=0 for one cycle, data driven, byteen=0101.
  - Then data='z and ddone pulse.
  - Readback word = 0x??AD??EF with old bytes preserved.
- ireq and dreq asserted same cycle, both held:
  - D granted first (reset token), then I.
  - Assert both again: I is granted only if token says I; verify alternation over 4 transactions.
- done held low 5 cycles in the middle of a burst (word 2):
  - adr/en stable throughout.
  - No extra ivalid; burst completes with correct word order.
- reset deasserted-to-asserted at word 1 of a refill:
  - en=0, data='z immediately (asynchronous).
  - No idone; next request after reset is served from IDLE normally.
- EXTMEM_CTRL_TIMEOUT_EN defined, TMO_CYC=8, done stuck 0:
  - Abort after 8 cycles; ddone pulse; tmo_err=1 until reset.

Source files
------------

// File: rtl/extmem_pkg.sv
// Shared definitions for the external memory controller: FSM encoding,
// bus widths and the default refill line length.
package extmem_pkg;

  localparam int DW             = 32;
  localparam int BW             = 4;
  localparam int LINE_WORDS_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IRD  = 3'd1,
    ST_DRD  = 3'd2,
    ST_DWR  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/extmem_ctrl_if.sv
// Cache-side request/response bundle of the external memory controller.
// The caches are the master; the controller is the slave.
interface extmem_ctrl_if #(
  parameter int AW = 13
);

  logic                      ireq;
  logic [AW-1:0]             iadr;
  logic [extmem_pkg::DW-1:0] irdata;
  logic                      ivalid;
  logic                      idone;
  logic                      dreq;
  logic                      drwb;
  logic [AW-1:0]             dadr;
  logic [extmem_pkg::DW-1:0] dwdata;
  logic [extmem_pkg::BW-1:0] dbyteen;
  logic [extmem_pkg::DW-1:0] drdata;
  logic                      dvalid;
  logic                      ddone;

  modport master (
    output ireq, iadr, dreq, drwb, dadr, dwdata, dbyteen,
    input  irdata, ivalid, idone, drdata, dvalid, ddone
  );

  modport slave (
    input  ireq, iadr, dreq, drwb, dadr, dwdata, dbyteen,
    output irdata, ivalid, idone, drdata, dvalid, ddone
  );

endinterface

// File: rtl/extmem_arb.sv
// Two-way round-robin arbiter between icache and dcache requests.
// The token starts on the D side and moves only after a contested grant.
module extmem_arb (
  input  logic ph1,
  input  logic reset,
  input  logic arb_en,
  input  logic ireq,
  input  logic dreq,
  output logic gnt_i,
  output logic gnt_d
);

  logic tok_d_r;

  // Grant the token holder on contention, otherwise whichever side is asking
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (arb_en && ireq && dreq) begin
      gnt_d = tok_d_r;
      gnt_i = ~tok_d_r;
    end else if (arb_en) begin
      gnt_i = ireq;
      gnt_d = dreq;
    end else begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
    end
  end

  // Token flips to the losing side only when both sides competed
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      tok_d_r <= 1'b1;
    end else if (arb_en && ireq && dreq) begin
      tok_d_r <= ~tok_d_r;
    end
  end

endmodule

// File: rtl/extmem_ctrl.sv
// External memory bus controller: arbitrates cache refills and write-throughs
// and sequences them word by word. Optional bus timeout: EXTMEM_CTRL_TIMEOUT_EN.
module extmem_ctrl
  import extmem_pkg::*;
#(
  parameter int AW         = 13,
  parameter int LINE_WORDS = LINE_WORDS_DEF
`ifdef EXTMEM_CTRL_TIMEOUT_EN
  ,
  parameter int TMO_CYC    = 255
`endif
) (
  input  logic          ph1,
  input  logic          reset,
  extmem_ctrl_if.slave  cif,
  output logic [AW-1:0] adr,
  inout  wire  [DW-1:0] data,
  output logic [BW-1:0] byteen,
  output logic          rwb,
  output logic          en,
  input  logic          done,
  output logic          busy
`ifdef EXTMEM_CTRL_TIMEOUT_EN
  ,
  output logic          tmo_err
`endif
);

  localparam int            CW        = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(LINE_WORDS - 1);
  localparam logic [AW-1:0] LINE_MASK = ~AW'(LINE_WORDS - 1);

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [AW-1:0] base_r;
  logic          side_d_r;
  logic [DW-1:0] wdata_r;
  logic [BW-1:0] wbe_r;
  logic          drive_r;
  logic [DW-1:0] irdata_r;
  logic [DW-1:0] drdata_r;
  logic          ivalid_r;
  logic          dvalid_r;
  logic          idone_r;
  logic          ddone_r;
  logic          gnt_i_s;
  logic          gnt_d_s;
  logic          arb_en_s;
  logic          tmo_hit_s;
  logic [AW-1:0] word_adr_s;
  logic [AW-1:0] next_adr_s;

  // Hold off arbitration during a done pulse so a requester can drop its request
  assign arb_en_s = (state_r == ST_IDLE) && !idone_r && !ddone_r;

  extmem_arb u_arb (
    .ph1    (ph1),
    .reset  (reset),
    .arb_en (arb_en_s),
    .ireq   (cif.ireq),
    .dreq   (cif.dreq),
    .gnt_i  (gnt_i_s),
    .gnt_d  (gnt_d_s)
  );

  // The counter is OR'd into the aligned base so the burst wraps inside its line
  assign word_adr_s = base_r | {{(AW-CW){1'b0}}, cnt_r};
  assign next_adr_s = base_r | {{(AW-CW){1'b0}}, cnt_r + CW'(1)};

  assign data        = drive_r ? wdata_r : {DW{1'bz}};
  assign cif.irdata  = irdata_r;
  assign cif.ivalid  = ivalid_r;
  assign cif.idone   = idone_r;
  assign cif.drdata  = drdata_r;
  assign cif.dvalid  = dvalid_r;
  assign cif.ddone   = ddone_r;

`ifdef EXTMEM_CTRL_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

  logic [15:0] tmo_cnt_r;
  logic        tmo_err_r;

  assign tmo_hit_s = en && !done && (tmo_cnt_r == TMO_LAST);
  assign tmo_err   = tmo_err_r;

  // Consecutive wait cycles on an enabled bus; any completed word restarts it
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      tmo_cnt_r <= 16'd0;
    end else if (en && !done && !tmo_hit_s) begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end else begin
      tmo_cnt_r <= 16'd0;
    end
  end

  // Sticky timeout flag
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      tmo_err_r <= 1'b0;
    end else if (tmo_hit_s) begin
      tmo_err_r <= 1'b1;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Transaction sequencer with registered bus and response outputs
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      base_r   <= '0;
      side_d_r <= 1'b0;
      wdata_r  <= '0;
      wbe_r    <= '0;
      drive_r  <= 1'b0;
      adr      <= '0;
      byteen   <= '0;
      rwb      <= 1'b1;
      en       <= 1'b0;
      busy     <= 1'b0;
      irdata_r <= '0;
      drdata_r <= '0;
      ivalid_r <= 1'b0;
      dvalid_r <= 1'b0;
      idone_r  <= 1'b0;
      ddone_r  <= 1'b0;
    end else begin
      ivalid_r <= 1'b0;
      dvalid_r <= 1'b0;
      idone_r  <= 1'b0;
      ddone_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (gnt_i_s) begin
            state_r  <= ST_IRD;
            base_r   <= cif.iadr & LINE_MASK;
            cnt_r    <= '0;
            side_d_r <= 1'b0;
            busy     <= 1'b1;
          end else if (gnt_d_s) begin
            cnt_r    <= '0;
            side_d_r <= 1'b1;
            busy     <= 1'b1;
            if (cif.drwb) begin
              state_r <= ST_DRD;
              base_r  <= cif.dadr & LINE_MASK;
            end else begin
              state_r <= ST_DWR;
              base_r  <= cif.dadr;
              wdata_r <= cif.dwdata;
              wbe_r   <= cif.dbyteen;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_IRD, ST_DRD: begin
          if (!en) begin
            en  <= 1'b1;
            rwb <= 1'b1;
            adr <= word_adr_s;
          end else if (done) begin
            if (state_r == ST_DRD) begin
              drdata_r <= data;
              dvalid_r <= 1'b1;
            end else begin
              irdata_r <= data;
              ivalid_r <= 1'b1;
            end
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == CNT_LAST) begin
              state_r <= ST_FIN;
              en      <= 1'b0;
            end else begin
              adr <= next_adr_s;
            end
          end else if (tmo_hit_s) begin
            state_r <= ST_FIN;
            en      <= 1'b0;
          end
        end
        ST_DWR: begin
          if (!en) begin
            en      <= 1'b1;
            rwb     <= 1'b0;
            adr     <= base_r;
            byteen  <= wbe_r;
            drive_r <= 1'b1;
          end else if (done || tmo_hit_s) begin
            state_r <= ST_FIN;
            en      <= 1'b0;
            rwb     <= 1'b1;
            byteen  <= '0;
            drive_r <= 1'b0;
          end
        end
        ST_FIN: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          if (side_d_r) begin
            ddone_r <= 1'b1;
          end else begin
            idone_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          en      <= 1'b0;
          rwb     <= 1'b1;
          byteen  <= '0;
          drive_r <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_extmem_ctrl.sv
// Self-checking bench for extmem_ctrl with a byte-enable memory model and
// queue scoreboards for addresses, refill words and grant order.
module tb_extmem_ctrl;
  import extmem_pkg::*;

  localparam int AW = 13;

  logic          ph1 = 1'b0;
  logic          reset = 1'b0;
  logic          done = 1'b1;
  wire  [31:0]   data;
  logic [AW-1:0] adr;
  logic [3:0]    byteen;
  logic          rwb;
  logic          en;
  logic          busy;
`ifdef EXTMEM_CTRL_TIMEOUT_EN
  logic          tmo_err;
`endif

  int total = 0;
  int bad = 0;

  always #5 ph1 = ~ph1;

  extmem_ctrl_if #(.AW(AW)) cif ();

  extmem_ctrl #(
    .AW         (AW),
    .LINE_WORDS (4)
`ifdef EXTMEM_CTRL_TIMEOUT_EN
    ,
    .TMO_CYC    (8)
`endif
  ) dut (
    .ph1    (ph1),
    .reset  (reset),
    .cif    (cif),
    .adr    (adr),
    .data   (data),
    .byteen (byteen),
    .rwb    (rwb),
    .en     (en),
    .done   (done),
    .busy   (busy)
`ifdef EXTMEM_CTRL_TIMEOUT_EN
    ,
    .tmo_err(tmo_err)
`endif
  );

  // Memory model: unwritten words read as 0xA000_0000 | address
  logic [(1<<AW)-1:0] wr_valid = '0;
  logic [31:0]        wr_mem [0:(1<<AW)-1];
  logic [31:0]        old_word;
  logic [31:0]        merged;

  assign old_word = wr_valid[adr] ? wr_mem[adr] : (32'hA000_0000 | {19'd0, adr});
  assign data     = (en && rwb) ? old_word : 32'hzzzz_zzzz;

  always_comb begin
    merged = old_word;
    for (int b = 0; b < 4; b++)
      if (byteen[b]) merged[8*b +: 8] = data[8*b +: 8];
  end

  always @(posedge ph1) begin
    if (en && !rwb && done) begin
      wr_valid[adr] <= 1'b1;
      wr_mem[adr]   <= merged;
    end
  end

  task automatic test_reset;
    @(posedge ph1); #1;
    total++; if (en !== 1'b0) begin bad++; $display("FAIL rst_en got=%b want=0", en); end
    total++; if (rwb !== 1'b1) begin bad++; $display("FAIL rst_rwb got=%b want=1", rwb); end
    total++; if (byteen !== 4'h0) begin bad++; $display("FAIL rst_byteen got=%h want=0", byteen); end
    total++; if (adr !== 13'h000) begin bad++; $display("FAIL rst_adr got=%h want=0", adr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++;
    if ({cif.ivalid, cif.dvalid, cif.idone, cif.ddone} !== 4'b0000) begin
      bad++; $display("FAIL rst_strobes got=%b want=0000", {cif.ivalid, cif.dvalid, cif.idone, cif.ddone});
    end
    reset = 1'b1;
    repeat (3) @(posedge ph1);
    #1;
    total++; if (busy !== 1'b0 || en !== 1'b0) begin bad++; $display("FAIL idle_quiet busy=%b en=%b want=0", busy, en); end
  endtask

  task automatic test_irefill;
    logic [AW-1:0] exp_a[$];
    logic [31:0]   exp_d[$];
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    int g = -1, nval = 0, first_v = -1, last_v = -1;
    bit fin = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_a.push_back(13'h010 + 13'(k));
      exp_d.push_back(32'hA000_0010 + 32'(k));
    end
    cif.iadr = 13'h013;
    cif.ireq = 1'b1;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(posedge ph1); #1;
      if (g < 0 && busy) g = i;
      if (en && done) begin
        total++;
        if (exp_a.size() == 0) begin bad++; $display("FAIL ird_adr extra access adr=%h", adr); end
        else begin
          ea = exp_a.pop_front();
          if (adr !== ea || rwb !== 1'b1) begin bad++; $display("FAIL ird_adr got=%h rwb=%b want=%h rwb=1", adr, rwb, ea); end
        end
      end
      if (cif.ivalid) begin
        nval++;
        if (first_v < 0) first_v = i;
        last_v = i;
        total++;
        if (exp_d.size() == 0) begin bad++; $display("FAIL ird_data extra word %h", cif.irdata); end
        else begin
          ed = exp_d.pop_front();
          if (cif.irdata !== ed) begin bad++; $display("FAIL ird_data got=%h want=%h", cif.irdata, ed); end
        end
      end
      if (cif.idone) begin
        fin = 1'b1;
        cif.ireq = 1'b0;
        total++; if (i - g !== 6) begin bad++; $display("FAIL ird_latency got=%0d want=6", i - g); end
      end
    end
    total++; if (!fin) begin bad++; $display("FAIL ird_timeout got=no idone want=idone"); cif.ireq = 1'b0; end
    total++; if (nval !== 4 || last_v - first_v !== 3) begin bad++; $display("FAIL ird_valid_run got=%0d span=%0d want=4 span=3", nval, last_v - first_v); end
  endtask

  task automatic test_write;
    int g = -1, nwr = 0;
    bit fin = 1'b0;
    logic [31:0] exp_word;
    exp_word = 32'hA0AD_01EF;
    cif.dadr    = 13'h100;
    cif.dwdata  = 32'hDEAD_BEEF;
    cif.dbyteen = 4'b0101;
    cif.drwb    = 1'b0;
    cif.dreq    = 1'b1;
    for (int i = 0; i < 20 && !fin; i++) begin
      @(posedge ph1); #1;
      if (g < 0 && busy) g = i;
      if (en && !rwb) begin
        nwr++;
        total++;
        if (data !== 32'hDEAD_BEEF || byteen !== 4'b0101 || adr !== 13'h100) begin
          bad++; $display("FAIL dwr_bus got=%h/%b/%h want=deadbeef/0101/100", data, byteen, adr);
        end
      end
      if (cif.ddone) begin
        fin = 1'b1;
        cif.dreq = 1'b0;
        total++; if (i - g !== 3) begin bad++; $display("FAIL dwr_latency got=%0d want=3", i - g); end
        total++; if (en !== 1'b0 || rwb !== 1'b1) begin bad++; $display("FAIL dwr_release got=en%b rwb%b want=en0 rwb1", en, rwb); end
      end
    end
    total++; if (!fin) begin bad++; $display("FAIL dwr_timeout got=no ddone want=ddone"); cif.dreq = 1'b0; end
    total++; if (nwr !== 1) begin bad++; $display("FAIL dwr_cycles got=%0d want=1", nwr); end
    total++; if (wr_mem[13'h100] !== exp_word) begin bad++; $display("FAIL dwr_readback got=%h want=%h", wr_mem[13'h100], exp_word); end
  endtask

  task automatic test_arbitration;
    bit          side_q[$];
    logic [31:0] exp_d[$];
    logic [31:0] ed;
    bit          es;
    int ndone = 0, nval = 0;
    side_q.push_back(1'b1); side_q.push_back(1'b0);
    side_q.push_back(1'b1); side_q.push_back(1'b0);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) exp_d.push_back(32'hA000_0024 + 32'(k));
    cif.iadr    = 13'h026;
    cif.dadr    = 13'h180;
    cif.dwdata  = 32'h0000_0000;
    cif.dbyteen = 4'hF;
    cif.drwb    = 1'b0;
    cif.ireq    = 1'b1;
    cif.dreq    = 1'b1;
    for (int i = 0; i < 200 && ndone < 4; i++) begin
      @(posedge ph1); #1;
      if (cif.ivalid) begin
        nval++;
        total++;
        if (exp_d.size() == 0) begin bad++; $display("FAIL arb_data extra word %h", cif.irdata); end
        else begin
          ed = exp_d.pop_front();
          if (cif.irdata !== ed) begin bad++; $display("FAIL arb_data got=%h want=%h", cif.irdata, ed); end
        end
      end
      if (cif.idone || cif.ddone) begin
        ndone++;
        total++;
        if (side_q.size() == 0) begin bad++; $display("FAIL arb_order extra done"); end
        else begin
          es = side_q.pop_front();
          if (cif.ddone !== es || cif.idone !== !es) begin
            bad++; $display("FAIL arb_order grant %0d got=d%b i%b want=d%b", ndone, cif.ddone, cif.idone, es);
          end
        end
        if (ndone == 4) begin cif.ireq = 1'b0; cif.dreq = 1'b0; end
      end
    end
    cif.ireq = 1'b0;
    cif.dreq = 1'b0;
    total++; if (ndone !== 4 || nval !== 8) begin bad++; $display("FAIL arb_count got=%0d done %0d words want=4 done 8 words", ndone, nval); end
  endtask

  task automatic test_stall;
    logic [AW-1:0] exp_a[$];
    logic [31:0]   exp_d[$];
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    int nval = 0, stall_left = 0;
    bit stalled = 1'b0, fin = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_a.push_back(13'h010 + 13'(k));
      exp_d.push_back(32'hA000_0010 + 32'(k));
    end
    cif.iadr = 13'h011;
    cif.ireq = 1'b1;
    for (int i = 0; i < 50 && !fin; i++) begin
      @(posedge ph1); #1;
      if (stall_left > 0) begin
        total++;
        if (en !== 1'b1 || adr !== 13'h012) begin bad++; $display("FAIL stall_hold got=en%b adr%h want=en1 adr012", en, adr); end
        stall_left--;
        if (stall_left == 0) done = 1'b1;
      end else if (!stalled && en && adr == 13'h012) begin
        done = 1'b0;
        stalled = 1'b1;
        stall_left = 5;
      end
      if (en && done) begin
        total++;
        if (exp_a.size() == 0) begin bad++; $display("FAIL stall_adr extra access adr=%h", adr); end
        else begin
          ea = exp_a.pop_front();
          if (adr !== ea) begin bad++; $display("FAIL stall_adr got=%h want=%h", adr, ea); end
        end
      end
      if (cif.ivalid) begin
        nval++;
        total++;
        if (exp_d.size() == 0) begin bad++; $display("FAIL stall_data extra word %h", cif.irdata); end
        else begin
          ed = exp_d.pop_front();
          if (cif.irdata !== ed) begin bad++; $display("FAIL stall_data got=%h want=%h", cif.irdata, ed); end
        end
      end
      if (cif.idone) begin fin = 1'b1; cif.ireq = 1'b0; end
    end
    done = 1'b1;
    cif.ireq = 1'b0;
    total++; if (!fin || nval !== 4 || !stalled) begin bad++; $display("FAIL stall_result got=fin%b words%0d want=fin1 words4", fin, nval); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] exp_d[$];
    logic [31:0] ed;
    int g = -1, nval = 0, ndone = 0, nen = 0;
    bit hit = 1'b0, fin = 1'b0;
    cif.iadr = 13'h010;
    cif.ireq = 1'b1;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge ph1); #1;
      if (en && adr == 13'h011) hit = 1'b1;
    end
    total++; if (!hit) begin bad++; $display("FAIL rmid_reach got=no word1 want=word1"); end
    #2;
    reset = 1'b0;
    cif.ireq = 1'b0;
    #1;
    total++; if (en !== 1'b0 || rwb !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rmid_abort got=en%b rwb%b busy%b want=en0 rwb1 busy0", en, rwb, busy); end
    @(posedge ph1); #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge ph1); #1;
      if (cif.idone) ndone++;
      if (en) nen++;
    end
    total++; if (ndone !== 0 || nen !== 0) begin bad++; $display("FAIL rmid_quiet got=%0d done %0d en want=0 0", ndone, nen); end
    for (int k = 0; k < 4; k++) exp_d.push_back(32'hA000_0030 + 32'(k));
    cif.iadr = 13'h030;
    cif.ireq = 1'b1;
    for (int i = 0; i < 30 && !fin; i++) begin
      @(posedge ph1); #1;
      if (g < 0 && busy) g = i;
      if (cif.ivalid) begin
        nval++;
        total++;
        if (exp_d.size() == 0) begin bad++; $display("FAIL rmid_data extra word %h", cif.irdata); end
        else begin
          ed = exp_d.pop_front();
          if (cif.irdata !== ed) begin bad++; $display("FAIL rmid_data got=%h want=%h", cif.irdata, ed); end
        end
      end
      if (cif.idone) begin
        fin = 1'b1;
        cif.ireq = 1'b0;
        total++; if (i - g !== 6) begin bad++; $display("FAIL rmid_latency got=%0d want=6", i - g); end
      end
    end
    cif.ireq = 1'b0;
    total++; if (!fin || nval !== 4) begin bad++; $display("FAIL rmid_after got=fin%b words%0d want=fin1 words4", fin, nval); end
  endtask

`ifdef EXTMEM_CTRL_TIMEOUT_EN
  task automatic test_timeout;
    int nen = 0;
    bit fin = 1'b0;
    total++; if (tmo_err !== 1'b0) begin bad++; $display("FAIL tmo_initial got=%b want=0", tmo_err); end
    done = 1'b0;
    cif.dadr    = 13'h300;
    cif.dwdata  = 32'h1234_5678;
    cif.dbyteen = 4'hF;
    cif.drwb    = 1'b0;
    cif.dreq    = 1'b1;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(posedge ph1); #1;
      if (en) nen++;
      if (cif.ddone) begin fin = 1'b1; cif.dreq = 1'b0; end
    end
    cif.dreq = 1'b0;
    total++; if (!fin || nen !== 8) begin bad++; $display("FAIL tmo_abort got=fin%b en_cycles%0d want=fin1 en_cycles8", fin, nen); end
    total++; if (tmo_err !== 1'b1) begin bad++; $display("FAIL tmo_flag got=%b want=1", tmo_err); end
    done = 1'b1;
    repeat (5) @(posedge ph1);
    #1;
    total++; if (tmo_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b want=1", tmo_err); end
    reset = 1'b0;
    #1;
    total++; if (tmo_err !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b want=0", tmo_err); end
    @(posedge ph1); #1;
    reset = 1'b1;
  endtask
`endif

  initial begin
    cif.ireq    = 1'b0;
    cif.iadr    = '0;
    cif.dreq    = 1'b0;
    cif.drwb    = 1'b0;
    cif.dadr    = '0;
    cif.dwdata  = '0;
    cif.dbyteen = '0;
    test_reset();
    test_irefill();
    test_write();
    test_arbitration();
    test_stall();
    test_reset_mid();
`ifdef EXTMEM_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
